// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline sequencer.
package pipe_ctrl_pkg;

    // Sequencer state.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FREEZE   = 2'd1,
        ST_EX_WAIT  = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    // Why the front end is not advancing (debug visibility).
    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MEM      = 2'd1,
        CAUSE_EX       = 2'd2,
        CAUSE_LOAD_USE = 2'd3
    } stall_cause_e;

    // 1 redirect cycle plus the instruction-ROM read latency.
    localparam int JUMP_FLUSH_CYCLES_DEF = 2;

    // Wide enough for the largest legal flush count (7).
    localparam int FLUSH_LEFT_W = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count enabled cycles, stop at the maximum value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates stall/flush requests from EX, ID and MEM
// and drives PC enable, per-stage stalls and the NOP-load flushes.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int JUMP_FLUSH_CYCLES = JUMP_FLUSH_CYCLES_DEF,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             load_use_i,
    input  logic             ex_busy_i,
    input  logic             mem_wait_i,
    output logic             pc_en_o,
    output logic             pc_jump_o,
    output logic [31:0]      jump_addr_o,
    output logic             stall_if_id_o,
    output logic             stall_id_ex_o,
    output logic             stall_ex_mem_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [FLUSH_LEFT_W-1:0] JUMP_LEFT = FLUSH_LEFT_W'(JUMP_FLUSH_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [FLUSH_LEFT_W-1:0] flush_left_q, flush_left_d;
    // Low for the first cycle after reset release so every output stays 0
    // until the first clock edge.
    logic                    run_q;
    logic                    in_redirect;

    // Leaving FREEZE/EX_WAIT resumes the redirect if flush cycles remain.
    assign in_redirect = (state_q == ST_REDIRECT) ||
                         (((state_q == ST_FREEZE) || (state_q == ST_EX_WAIT)) &&
                          (flush_left_q != '0));

    // Priority resolution: mem_wait > ex_busy > jump > redirect/load-use.
    always_comb begin
        state_d        = state_q;
        flush_left_d   = flush_left_q;
        pc_en_o        = 1'b0;
        pc_jump_o      = 1'b0;
        jump_addr_o    = '0;
        stall_if_id_o  = 1'b0;
        stall_id_ex_o  = 1'b0;
        stall_ex_mem_o = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        if (!run_q) begin
            state_d = ST_RUN;
        end else if (mem_wait_i) begin
            // Whole front end frozen; flush_left kept for after the wait.
            state_d        = ST_FREEZE;
            stall_if_id_o  = 1'b1;
            stall_id_ex_o  = 1'b1;
            stall_ex_mem_o = 1'b1;
        end else if (ex_busy_i) begin
            // EX inserts its own bubble into EX/MEM.
            state_d       = ST_EX_WAIT;
            stall_if_id_o = 1'b1;
            stall_id_ex_o = 1'b1;
        end else if (jump_en_i) begin
            pc_en_o       = 1'b1;
            pc_jump_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            flush_left_d  = JUMP_LEFT;
            state_d       = (JUMP_LEFT != '0) ? ST_REDIRECT : ST_RUN;
        end else if (in_redirect) begin
            // ID holds a NOP here, so load_use_i is meaningless.
            pc_en_o       = 1'b1;
            flush_if_id_o = 1'b1;
            if (flush_left_q != '0) begin
                flush_left_d = flush_left_q - 1'b1;
            end
            state_d = (flush_left_q > FLUSH_LEFT_W'(1)) ? ST_REDIRECT : ST_RUN;
        end else if (load_use_i) begin
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            state_d       = ST_RUN;
        end else begin
            pc_en_o = 1'b1;
            state_d = ST_RUN;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            flush_left_q <= '0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            run_q        <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (~pc_en_o),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_if_id_o | flush_id_ex_o),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl; a second 4-bit-counter instance
// shares the stimulus to exercise counter saturation.
module tb_pipe_ctrl;

    typedef struct packed {
        logic        pc_en;
        logic        pc_jump;
        logic [31:0] addr;
        logic        st_if_id;
        logic        st_id_ex;
        logic        st_ex_mem;
        logic        fl_if_id;
        logic        fl_id_ex;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        load_use_i;
    logic        ex_busy_i;
    logic        mem_wait_i;

    logic        pc_en_o, pc_jump_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o;
    logic        flush_if_id_o, flush_id_ex_o;
    logic [31:0] jump_addr_o, stall_cnt_o, flush_cnt_o;

    logic        s_pc_en, s_pc_jump, s_st1, s_st2, s_st3, s_fl1, s_fl2;
    logic [31:0] s_addr;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_asrt = 0;
    int n_fail = 0;

    outs_t outs;
    outs_t sb_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.JUMP_FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .load_use_i(load_use_i), .ex_busy_i(ex_busy_i), .mem_wait_i(mem_wait_i),
        .pc_en_o(pc_en_o), .pc_jump_o(pc_jump_o), .jump_addr_o(jump_addr_o),
        .stall_if_id_o(stall_if_id_o), .stall_id_ex_o(stall_id_ex_o),
        .stall_ex_mem_o(stall_ex_mem_o), .flush_if_id_o(flush_if_id_o),
        .flush_id_ex_o(flush_id_ex_o), .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
    );

    pipe_ctrl #(.JUMP_FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .load_use_i(load_use_i), .ex_busy_i(ex_busy_i), .mem_wait_i(mem_wait_i),
        .pc_en_o(s_pc_en), .pc_jump_o(s_pc_jump), .jump_addr_o(s_addr),
        .stall_if_id_o(s_st1), .stall_id_ex_o(s_st2), .stall_ex_mem_o(s_st3),
        .flush_if_id_o(s_fl1), .flush_id_ex_o(s_fl2),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    assign outs = '{pc_en_o, pc_jump_o, jump_addr_o, stall_if_id_o, stall_id_ex_o,
                    stall_ex_mem_o, flush_if_id_o, flush_id_ex_o};

    function automatic outs_t mk(logic pe, logic pj, logic [31:0] a,
                                 logic s1, logic s2, logic s3, logic f1, logic f2);
        return '{pe, pj, a, s1, s2, s3, f1, f2};
    endfunction

    localparam outs_t O_ZERO = '0;
    localparam outs_t O_RUN  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outs_t O_RDR  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam outs_t O_LU   = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam outs_t O_EX   = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam outs_t O_MW   = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    task automatic chk_outs(string tag, outs_t obs, outs_t exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(string tag, logic [31:0] obs, logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare at negedge.
    task automatic step(string tag, logic ju, logic [31:0] ja, logic lu,
                        logic eb, logic mw, outs_t e);
        outs_t exp_v;
        jump_en_i   = ju;
        jump_addr_i = ja;
        load_use_i  = lu;
        ex_busy_i   = eb;
        mem_wait_i  = mw;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        exp_v = sb_q.pop_front();
        chk_outs(tag_q.pop_front(), outs, exp_v);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(string tag, outs_t e);
        step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, e);
    endtask

    // Protocol: a jump is never resolved while a multi-cycle op is busy.
    always @(posedge clk) begin
        if (rst && jump_en_i) begin
            n_asrt++;
            assert (!ex_busy_i) else begin
                n_fail++;
                $error("FAIL protocol_jump_busy: observed ex_busy=%b expected 0", ex_busy_i);
            end
        end
    end

    initial begin
        // Reset with live inputs: outputs must stay 0.
        rst = 1'b0; jump_en_i = 1'b1; jump_addr_i = 32'hDEAD_BEEF;
        load_use_i = 1'b0; ex_busy_i = 1'b0; mem_wait_i = 1'b0;
        #2;
        chk_outs("reset_outs", outs, O_ZERO);
        chk_cnt("reset_stall_cnt", stall_cnt_o, 32'd0);
        chk_cnt("reset_flush_cnt", flush_cnt_o, 32'd0);
        @(posedge clk); #1;
        jump_en_i = 1'b0; jump_addr_i = '0; rst = 1'b1;
        #1;
        chk_outs("startup_outs", outs, O_ZERO);
        @(posedge clk); #1;
        idle("first_run", O_RUN);
        chk_cnt("startup_stall_cnt", stall_cnt_o, 32'd1);
        chk_cnt("startup_flush_cnt", flush_cnt_o, 32'd0);

        // Jump: two IF/ID flush cycles, one ID/EX flush cycle.
        step("jump_100", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, mk(1, 1, 32'h100, 0, 0, 0, 1, 1));
        idle("jump_flush2", O_RDR);
        idle("jump_done", O_RUN);
        chk_cnt("jump_flush_cnt", flush_cnt_o, 32'd2);

        // Load-use: one bubble cycle.
        step("load_use", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, O_LU);
        idle("load_use_done", O_RUN);
        chk_cnt("load_use_stall_cnt", stall_cnt_o, 32'd2);

        // Long EX op then jump on the exit cycle.
        for (int i = 0; i < 33; i++) step("ex_busy", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, O_EX);
        step("ex_exit_jump", 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, mk(1, 1, 32'h200, 0, 0, 0, 1, 1));
        idle("ex_jump_flush2", O_RDR);
        idle("ex_jump_done", O_RUN);
        chk_cnt("ex_stall_cnt", stall_cnt_o, 32'd35);
        chk_cnt("ex_flush_cnt", flush_cnt_o, 32'd5);
        chk_cnt("sat_stall_cnt_early", {28'd0, s_stall_cnt}, 32'd15);

        // mem_wait freezes mid-redirect; one flush cycle remains afterwards.
        step("mw_jump", 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, mk(1, 1, 32'h300, 0, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++) step("mem_wait", 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, O_MW);
        idle("mw_resume_flush", O_RDR);
        idle("mw_done", O_RUN);
        chk_cnt("mw_stall_cnt", stall_cnt_o, 32'd38);
        chk_cnt("mw_flush_cnt", flush_cnt_o, 32'd7);

        // load_use ignored in REDIRECT.
        step("lu_jump", 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, mk(1, 1, 32'h400, 0, 0, 0, 1, 1));
        step("lu_in_redirect", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, O_RDR);
        idle("lu_rdr_done", O_RUN);
        chk_cnt("lu_rdr_flush_cnt", flush_cnt_o, 32'd9);

        // Saturation: 20 load-use cycles.
        for (int i = 0; i < 20; i++) step("sat_lu", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, O_LU);
        idle("sat_done", O_RUN);
        chk_cnt("sat_stall_cnt", {28'd0, s_stall_cnt}, 32'd15);
        chk_cnt("sat_flush_cnt", {28'd0, s_flush_cnt}, 32'd15);
        chk_cnt("wide_stall_cnt", stall_cnt_o, 32'd58);
        chk_cnt("wide_flush_cnt", flush_cnt_o, 32'd29);

        // Reset in REDIRECT with one flush cycle left.
        step("rst_jump", 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, mk(1, 1, 32'h500, 0, 0, 0, 1, 1));
        jump_en_i = 1'b0; jump_addr_i = '0;
        rst = 1'b0;
        #1;
        chk_outs("midrst_outs", outs, O_ZERO);
        chk_cnt("midrst_stall_cnt", stall_cnt_o, 32'd0);
        chk_cnt("midrst_flush_cnt", flush_cnt_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_outs("midrst_startup", outs, O_ZERO);
        @(posedge clk); #1;
        idle("midrst_run", O_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
